morse_tx: RTL

Morse transmitter: the encoder-side counterpart of the `decoder` receive path. It accepts 6-bit character codes over a valid/ready handshake and emits an on/off keying signal with standard Morse timing. Dot = 1 unit, dash = 3 units, intra-character gap = 1 unit, inter-character gap = 3 units, word gap = 7 units. It sits between the character source (keyboard/UART/test logic) and the key/sidetone output pin.

---
 rtl/morse_pkg.sv | 32 +++
 rtl/morse_tx_if.sv | 10 +
 rtl/morse_encode_lut.sv | 60 ++++++
 rtl/morse_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter: character codes, FSM states
// and timing multipliers expressed in Morse units.
package morse_pkg;

  localparam logic [5:0] MORSE_A = 6'd0,  MORSE_B = 6'd1,  MORSE_C = 6'd2,  MORSE_D = 6'd3;
  localparam logic [5:0] MORSE_E = 6'd4,  MORSE_F = 6'd5,  MORSE_G = 6'd6,  MORSE_H = 6'd7;
  localparam logic [5:0] MORSE_I = 6'd8,  MORSE_J = 6'd9,  MORSE_K = 6'd10, MORSE_L = 6'd11;
  localparam logic [5:0] MORSE_M = 6'd12, MORSE_N = 6'd13, MORSE_O = 6'd14, MORSE_P = 6'd15;
  localparam logic [5:0] MORSE_Q = 6'd16, MORSE_R = 6'd17, MORSE_S = 6'd18, MORSE_T = 6'd19;
  localparam logic [5:0] MORSE_U = 6'd20, MORSE_V = 6'd21, MORSE_W = 6'd22, MORSE_X = 6'd23;
  localparam logic [5:0] MORSE_Y = 6'd24, MORSE_Z = 6'd25;
  localparam logic [5:0] MORSE_0 = 6'd26, MORSE_1 = 6'd27, MORSE_2 = 6'd28, MORSE_3 = 6'd29;
  localparam logic [5:0] MORSE_4 = 6'd30, MORSE_5 = 6'd31, MORSE_6 = 6'd32, MORSE_7 = 6'd33;
  localparam logic [5:0] MORSE_8 = 6'd34, MORSE_9 = 6'd35;
  localparam logic [5:0] MORSE_SPACE = 6'd36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_GAP,
    ST_WORD
  } morse_tx_state_t;

  // Durations in units; WORD_EXTRA tops up the preceding 3U gap to a 7U word gap.
  localparam logic [2:0] DOT        = 3'd1;
  localparam logic [2:0] DASH       = 3'd3;
  localparam logic [2:0] ELEM_GAP   = 3'd1;
  localparam logic [2:0] CHAR_GAP   = 3'd3;
  localparam logic [2:0] WORD_EXTRA = 3'd4;

endpackage

// File: rtl/morse_tx_if.sv
// Character handshake between a character source (master) and the Morse
// transmitter (slave).
interface morse_tx_if;
  logic       char_valid;
  logic [5:0] char_data;
  logic       char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/morse_encode_lut.sv
// Combinational ITU Morse lookup: code -> element count and pattern
// (first element in pat[len-1], 1 = dash).
module morse_encode_lut
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output logic [2:0] len,
  output logic [4:0] pat,
  output logic       is_space,
  output logic       is_invalid
);

  always_comb begin
    len        = 3'd0;
    pat        = 5'd0;
    is_space   = 1'b0;
    is_invalid = 1'b0;
    case (code)
      MORSE_A: begin len = 3'd2; pat = 5'b00001; end
      MORSE_B: begin len = 3'd4; pat = 5'b01000; end
      MORSE_C: begin len = 3'd4; pat = 5'b01010; end
      MORSE_D: begin len = 3'd3; pat = 5'b00100; end
      MORSE_E: begin len = 3'd1; pat = 5'b00000; end
      MORSE_F: begin len = 3'd4; pat = 5'b00010; end
      MORSE_G: begin len = 3'd3; pat = 5'b00110; end
      MORSE_H: begin len = 3'd4; pat = 5'b00000; end
      MORSE_I: begin len = 3'd2; pat = 5'b00000; end
      MORSE_J: begin len = 3'd4; pat = 5'b00111; end
      MORSE_K: begin len = 3'd3; pat = 5'b00101; end
      MORSE_L: begin len = 3'd4; pat = 5'b00100; end
      MORSE_M: begin len = 3'd2; pat = 5'b00011; end
      MORSE_N: begin len = 3'd2; pat = 5'b00010; end
      MORSE_O: begin len = 3'd3; pat = 5'b00111; end
      MORSE_P: begin len = 3'd4; pat = 5'b00110; end
      MORSE_Q: begin len = 3'd4; pat = 5'b01101; end
      MORSE_R: begin len = 3'd3; pat = 5'b00010; end
      MORSE_S: begin len = 3'd3; pat = 5'b00000; end
      MORSE_T: begin len = 3'd1; pat = 5'b00001; end
      MORSE_U: begin len = 3'd3; pat = 5'b00001; end
      MORSE_V: begin len = 3'd4; pat = 5'b00001; end
      MORSE_W: begin len = 3'd3; pat = 5'b00011; end
      MORSE_X: begin len = 3'd4; pat = 5'b01001; end
      MORSE_Y: begin len = 3'd4; pat = 5'b01011; end
      MORSE_Z: begin len = 3'd4; pat = 5'b01100; end
      MORSE_0: begin len = 3'd5; pat = 5'b11111; end
      MORSE_1: begin len = 3'd5; pat = 5'b01111; end
      MORSE_2: begin len = 3'd5; pat = 5'b00111; end
      MORSE_3: begin len = 3'd5; pat = 5'b00011; end
      MORSE_4: begin len = 3'd5; pat = 5'b00001; end
      MORSE_5: begin len = 3'd5; pat = 5'b00000; end
      MORSE_6: begin len = 3'd5; pat = 5'b10000; end
      MORSE_7: begin len = 3'd5; pat = 5'b11000; end
      MORSE_8: begin len = 3'd5; pat = 5'b11100; end
      MORSE_9: begin len = 3'd5; pat = 5'b11110; end
      MORSE_SPACE: is_space = 1'b1;
      default:     is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts character codes and keys them out with standard
// unit timing. Define MORSE_TX_SIDETONE_EN to build the sidetone generator.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = 5_000_000,
  parameter int unsigned TONE_HALF_CYCLES = 50_000
) (
  input  logic         clk_100Mhz,
  input  logic         reset,
  morse_tx_if.slave    char_if,
  output logic         key,
  output logic         tone,
  output logic         busy,
  output logic         char_done,
  output logic         char_err
);

  localparam int unsigned CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  if (UNIT_CYCLES < 2) begin : g_bad_unit
    $error("morse_tx: UNIT_CYCLES must be at least 2");
  end
  if (TONE_HALF_CYCLES < 1) begin : g_bad_tone
    $error("morse_tx: TONE_HALF_CYCLES must be at least 1");
  end

  morse_tx_state_t r_state;
  logic [CW-1:0]   r_cyc;
  logic [2:0]      r_units;
  logic [2:0]      r_idx;
  logic [4:0]      r_pat;
  logic            r_key, r_busy, r_done, r_err;

  logic [2:0] w_len;
  logic [4:0] w_pat;
  logic       w_is_space, w_is_invalid;
  logic [2:0] w_first_idx, w_next_idx;

  morse_encode_lut u_lut (
    .code       (char_if.char_data),
    .len        (w_len),
    .pat        (w_pat),
    .is_space   (w_is_space),
    .is_invalid (w_is_invalid)
  );

  assign w_first_idx        = w_len - 3'd1;
  assign w_next_idx         = r_idx - 3'd1;
  assign char_if.char_ready = (r_state == ST_IDLE);

  // Each non-idle state runs r_units whole units; r_cyc wraps once per unit.
  always_ff @(posedge clk_100Mhz) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_units <= '0;
      r_idx   <= '0;
      r_pat   <= '0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_cyc <= '0;
        if (char_if.char_valid) begin
          if (w_is_invalid) begin
            r_err <= 1'b1;
          end else if (w_is_space) begin
            r_state <= ST_WORD;
            r_units <= WORD_EXTRA;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_MARK;
            r_pat   <= w_pat;
            r_idx   <= w_first_idx;
            r_units <= w_pat[w_first_idx] ? DASH : DOT;
            r_key   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
      end else if (r_cyc != CYC_LAST) begin
        r_cyc <= r_cyc + 1'b1;
      end else begin
        r_cyc <= '0;
        if (r_units != 3'd1) begin
          r_units <= r_units - 3'd1;
        end else begin
          case (r_state)
            ST_MARK: begin
              r_key <= 1'b0;
              if (r_idx != 3'd0) begin
                r_state <= ST_SPACE;
                r_units <= ELEM_GAP;
              end else begin
                r_state <= ST_GAP;
                r_units <= CHAR_GAP;
              end
            end
            ST_SPACE: begin
              r_state <= ST_MARK;
              r_idx   <= w_next_idx;
              r_units <= r_pat[w_next_idx] ? DASH : DOT;
              r_key   <= 1'b1;
            end
            default: begin
              r_state <= ST_IDLE;
              r_units <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign key       = r_key;
  assign busy      = r_busy;
  assign char_done = r_done;
  assign char_err  = r_err;

`ifdef MORSE_TX_SIDETONE_EN
  localparam int unsigned TW = $clog2(TONE_HALF_CYCLES + 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF_CYCLES - 1);

  logic [TW-1:0] r_tone_cnt;
  logic          r_tone;

  // Held at zero while keyed off so every mark starts on a fresh low half-period.
  always_ff @(posedge clk_100Mhz) begin
    if (!reset || !r_key) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_tone_cnt == TONE_LAST) begin
      r_tone_cnt <= '0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + 1'b1;
    end
  end

  assign tone = r_tone;
`else
  assign tone = 1'b0;
`endif

endmodule
